// File: rtl/mem_pkg.sv
// Shared encodings and alignment helper for the MEM-stage data memory.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Illegal size encoding or an address not aligned to the access size.
  function automatic logic size_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store replication/byte enables and load select/extend.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NB     = DATA_W / 8
) (
  input  logic [1:0]        size,
  input  logic              sgn,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rword,
  output logic [DATA_W-1:0] wdata_rep,
  output logic [NB-1:0]     be,
  output logic [DATA_W-1:0] rdata_ext
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign ld_byte = rword[{addr_lo, 3'b000} +: 8];
  assign ld_half = rword[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    wdata_rep = wdata;
    be        = '0;
    rdata_ext = rword;
    case (size)
      SZ_BYTE: begin
        wdata_rep = {NB{wdata[7:0]}};
        be        = NB'(1) << addr_lo;
        rdata_ext = {{(DATA_W-8){sgn & ld_byte[7]}}, ld_byte};
      end
      SZ_HALF: begin
        wdata_rep = {(NB/2){wdata[15:0]}};
        be        = NB'(3) << {addr_lo[1], 1'b0};
        rdata_ext = {{(DATA_W-16){sgn & ld_half[15]}}, ld_half};
      end
      SZ_WORD: begin
        wdata_rep = wdata;
        be        = '1;
        rdata_ext = rword;
      end
      default: begin
        wdata_rep = wdata;
        be        = '0;
        rdata_ext = rword;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage data memory: sized/extended loads, byte-enabled stores, wait-state stall handshake.
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              addr_err
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic [ADDR_W-1:0]   idx;
  logic [DATA_W-1:0]   rd_word, wdata_rep, ld_ext;
  logic [NB-1:0]       be;
  logic                go, wr_en;
  logic                unused_addr;

  // Upper address bits are intentionally dropped so accesses wrap.
  assign idx         = req_addr[ADDR_W+1:2];
  assign unused_addr = ^req_addr[31:ADDR_W+2];
  assign rd_word     = mem[idx];

  assign addr_err = req_valid & size_misaligned(req_size, req_addr[1:0]);
  assign go       = req_valid & ~addr_err;

  mem_lane_align #(.DATA_W(DATA_W), .NB(NB)) u_align (
    .size      (req_size),
    .sgn       (req_signed),
    .addr_lo   (req_addr[1:0]),
    .wdata     (req_wdata),
    .rword     (rd_word),
    .wdata_rep (wdata_rep),
    .be        (be),
    .rdata_ext (ld_ext)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          if (WAIT_CYCLES == 0) begin
            state_d = ST_DONE;
            if (!req_we) rdata_d = ld_ext;
          end else begin
            state_d = ST_BUSY;
            cnt_d   = CNT_W'(WAIT_CYCLES - 1);
          end
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          if (!req_we) rdata_d = ld_ext;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Store commits on the edge leaving DONE; reset drops it entirely.
  assign wr_en = (state_q == ST_DONE) & req_we & ~addr_err & ~rst;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < NB; k++) begin
        if (be[k]) mem[idx][8*k +: 8] <= wdata_rep[8*k +: 8];
      end
    end
  end

  assign stall      = ((state_q == ST_IDLE) & go) | (state_q == ST_BUSY);
  assign resp_valid = (state_q == ST_DONE);
  assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed checks of data_mem_ctrl at WAIT_CYCLES = 1, 0 and 3.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid  [3];
  logic        req_we     [3];
  logic [1:0]  req_size   [3];
  logic        req_signed [3];
  logic [31:0] req_addr   [3];
  logic [31:0] req_wdata  [3];
  logic        stall      [3];
  logic        resp_valid [3];
  logic [31:0] resp_rdata [3];
  logic        addr_err   [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Instance 0: WAIT_CYCLES=1, instance 1: 0, instance 2: 3.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_mem_ctrl #(
      .DATA_W(32), .ADDR_W(10),
      .WAIT_CYCLES((g == 0) ? 1 : (g == 1) ? 0 : 3)
    ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid[g]),
      .req_we     (req_we[g]),
      .req_size   (req_size[g]),
      .req_signed (req_signed[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .stall      (stall[g]),
      .resp_valid (resp_valid[g]),
      .resp_rdata (resp_rdata[g]),
      .addr_err   (addr_err[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // One full access on instance d; reports response cycle and stall-cycle count.
  task automatic access(input int d, input logic we, input logic [1:0] sz, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output int resp_cyc, output int stall_cnt);
    @(posedge clk); #1;
    req_valid[d] = 1'b1; req_we[d] = we; req_size[d] = sz;
    req_signed[d] = sgn; req_addr[d] = addr; req_wdata[d] = wd;
    resp_cyc = 0; stall_cnt = 0; rd = 'x;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (stall[d]) stall_cnt++;
      if (resp_valid[d]) begin
        resp_cyc = c;
        rd = resp_rdata[d];
        break;
      end
    end
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
  endtask

  // Drive a request expected to be rejected; check flags, then drop it.
  task automatic bad_req(input string tag, input logic we, input logic [1:0] sz, input logic [31:0] addr);
    @(posedge clk); #1;
    req_valid[0] = 1'b1; req_we[0] = we; req_size[0] = sz;
    req_signed[0] = 1'b0; req_addr[0] = addr; req_wdata[0] = 32'h1234_5678;
    @(negedge clk);
    chk({tag, "_err"}, 32'(addr_err[0]), 32'd1);
    chk({tag, "_stall"}, 32'(stall[0]), 32'd0);
    @(posedge clk); @(negedge clk);
    chk({tag, "_resp"}, 32'(resp_valid[0]), 32'd0);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
  endtask

  logic [31:0] rd;
  int rc, sc;

  initial begin
    for (int d = 0; d < 3; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_size[d] = 2'b10;
      req_signed[d] = 1'b0; req_addr[d] = '0; req_wdata[d] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 32'(stall[0]), 32'd0);
    chk("rst_resp", 32'(resp_valid[0]), 32'd0);
    chk("rst_rdata", resp_rdata[0], 32'h0);
    rst = 1'b0;

    // WAIT_CYCLES=1: word round trip and timing
    access(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, rd, rc, sc);
    chk("sw_cyc", 32'(rc), 32'd3);
    chk("sw_stall", 32'(sc), 32'd2);
    access(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, rc, sc);
    chk("lw_data", rd, 32'hDEAD_BEEF);
    chk("lw_cyc", 32'(rc), 32'd3);
    chk("lw_stall", 32'(sc), 32'd2);

    // Byte store into the middle of the word, then sized loads
    access(0, 1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_0080, rd, rc, sc);
    chk("sb_keeps_rdata", rd, 32'hDEAD_BEEF);
    access(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, rc, sc);
    chk("lw_after_sb", rd, 32'hDEAD_80EF);
    access(0, 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, rd, rc, sc);
    chk("lb_s", rd, 32'hFFFF_FF80);
    access(0, 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, rd, rc, sc);
    chk("lbu", rd, 32'h0000_0080);
    access(0, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, rd, rc, sc);
    chk("lh_s", rd, 32'hFFFF_DEAD);
    access(0, 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, rd, rc, sc);
    chk("lhu_lo", rd, 32'h0000_80EF);
    access(0, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, rd, rc, sc);
    chk("lb_s_top", rd, 32'hFFFF_FFDE);
    access(0, 1'b1, 2'b01, 1'b0, 32'h12, 32'hABCD_1234, rd, rc, sc);
    access(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, rc, sc);
    chk("lw_after_sh", rd, 32'h1234_80EF);

    // Rejected accesses leave memory untouched
    bad_req("lw12", 1'b0, 2'b10, 32'h12);
    bad_req("sh13", 1'b1, 2'b01, 32'h13);
    bad_req("sz11", 1'b0, 2'b11, 32'h0);
    bad_req("sw11", 1'b1, 2'b10, 32'h11);
    access(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, rc, sc);
    chk("mem_unchanged", rd, 32'h1234_80EF);

    // Address wrap
    access(0, 1'b1, 2'b10, 1'b0, 32'h1000, 32'h55, rd, rc, sc);
    access(0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, rd, rc, sc);
    chk("wrap", rd, 32'h55);

    // Reset during BUSY drops the store
    access(0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h1122_3344, rd, rc, sc);
    access(0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, rd, rc, sc);
    @(posedge clk); #1;
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_size[0] = 2'b10;
    req_addr[0] = 32'h20; req_wdata[0] = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    chk("busy_stall", 32'(stall[0]), 32'd1);
    rst = 1'b1; #1;
    req_valid[0] = 1'b0; #1;
    chk("rst_busy_resp", 32'(resp_valid[0]), 32'd0);
    chk("rst_busy_stall", 32'(stall[0]), 32'd0);
    chk("rst_busy_rdata", resp_rdata[0], 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    access(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, rc, sc);
    chk("rst_no_write", rd, 32'h1122_3344);

    // WAIT_CYCLES=0
    access(1, 1'b1, 2'b10, 1'b0, 32'h0, 32'h1, rd, rc, sc);
    chk("w0_sw_cyc", 32'(rc), 32'd2);
    chk("w0_sw_stall", 32'(sc), 32'd1);
    access(1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, rd, rc, sc);
    chk("w0_lw", rd, 32'h1);

    // WAIT_CYCLES=3
    access(2, 1'b1, 2'b10, 1'b0, 32'h4, 32'hA5A5_5A5A, rd, rc, sc);
    chk("w3_sw_cyc", 32'(rc), 32'd5);
    chk("w3_sw_stall", 32'(sc), 32'd4);
    access(2, 1'b0, 2'b00, 1'b1, 32'h6, 32'h0, rd, rc, sc);
    chk("w3_lb", rd, 32'hFFFF_FFA5);
    chk("w3_lb_cyc", 32'(rc), 32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
